// File: rtl/sram_bist_ctrl.sv
// March-style write/readback BIST for a single-port sync SRAM.
// Writes seed+addr everywhere, reads back, counts and locates mismatches.
module sram_bist_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_D = ADDR_W'(READ_LAT - 1);

  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic go;

  logic              cen_d, wen_d, busy_d, done_d, pass_d;
  logic [ADDR_W-1:0] addr_d, first_d;
  logic [DATA_W-1:0] din_d;
  logic [7:0]        err_d;

  logic [READ_LAT-1:0] pv;
  logic [DATA_W-1:0]   pexp  [READ_LAT];
  logic [ADDR_W-1:0]   paddr [READ_LAT];
  logic                mism;

  assign go = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = WRITE;
      end
      WRITE: begin
        if (cnt == LAST_A) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ADDR_W'(1);
        end
      end
      READ: begin
        if (cnt == LAST_A) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (cnt == LAST_D) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state so they land registered.
  always_comb begin
    seed_d = go ? seed : seed_q;
    cen_d  = 1'b1;
    wen_d  = 1'b1;
    addr_d = '0;
    din_d  = '0;
    unique case (state_d)
      WRITE: begin
        cen_d  = 1'b0;
        wen_d  = 1'b0;
        addr_d = cnt_d;
        din_d  = seed_d + DATA_W'(cnt_d);
      end
      READ: begin
        cen_d  = 1'b0;
        addr_d = cnt_d;
      end
      default: begin
        cen_d = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    mism = pv[READ_LAT-1] &&
           (mem_dout != pexp[READ_LAT-1]);
    err_d   = err_count;
    first_d = first_err_addr;
    if (go) begin
      err_d   = '0;
      first_d = '0;
    end else if (mism) begin
      if (err_count != 8'hFF) err_d = err_count + 8'd1;
      if (err_count == 8'd0) first_d = paddr[READ_LAT-1];
    end
    pass_d = pass;
    if (go) pass_d = 1'b0;
    else if (state_d == DONE) pass_d = (err_d == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q         <= '0;
      mem_cen        <= 1'b1;
      mem_wen        <= 1'b1;
      mem_addr       <= '0;
      mem_din        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      seed_q         <= seed_d;
      mem_cen        <= cen_d;
      mem_wen        <= wen_d;
      mem_addr       <= addr_d;
      mem_din        <= din_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_err_addr <= first_d;
    end
  end

  // Expected data trails each read issue by READ_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= (state == READ);
      for (int i = 1; i < READ_LAT; i++) pv[i] <= pv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pexp[0]  <= seed_q + DATA_W'(mem_addr);
    paddr[0] <= mem_addr;
    for (int i = 1; i < READ_LAT; i++) begin
      pexp[i]  <= pexp[i-1];
      paddr[i] <= paddr[i-1];
    end
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Scoreboard bench for sram_bist_ctrl with a behavioural 128x16 SRAM.
// Expected results come from a per-test reference model of the readback.
`timescale 1ns/1ps
module tb_sram_bist_ctrl;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int DEPTH = 128;
  localparam int RL = 1;

  logic          clk, rst, start;
  logic [DW-1:0] seed;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          busy, done, pass;
  logic [7:0]    err_count;
  logic [AW-1:0] first_err_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int fault = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_a;

  typedef struct {
    int            cyc;
    logic          pass;
    logic [7:0]    err;
    logic [AW-1:0] first;
  } exp_t;

  exp_t q[$];

  sram_bist_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .mem_cen(mem_cen), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) begin
        mem[mem_addr] <= mem_din;
      end else begin
        rd_q <= mem[mem_addr];
        rd_a <= mem_addr;
      end
    end
  end

  // Fault injection on the read path only; stored contents stay intact.
  always_comb begin
    mem_dout = rd_q;
    if (fault == 1 && (rd_a == 7'd5 || rd_a == 7'd9))
      mem_dout = rd_q ^ 16'h0001;
    else if (fault == 2)
      mem_dout = '0;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] s,
                                 input int f);
    exp_t r;
    int errs;
    int first;
    logic [DW-1:0] wr, rd;
    errs = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      wr = s + DW'(a);
      rd = wr;
      if (f == 1 && (a == 5 || a == 9)) rd = wr ^ 16'h0001;
      if (f == 2) rd = '0;
      if (rd != wr) begin
        if (errs == 0) first = a;
        if (errs < 255) errs++;
      end
    end
    r.cyc = 0;
    r.pass = (errs == 0);
    r.err = 8'(errs);
    r.first = AW'(first);
    return r;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("pass", 32'(pass), 32'(e.pass));
          chk("err_count", 32'(err_count), 32'(e.err));
          chk("first_err_addr", 32'(first_err_addr),
              32'(e.first));
          chk("busy_at_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic run_test(input logic [DW-1:0] s,
                          input int f, input bit poke);
    exp_t e;
    int base, t, d0, r;
    e = model(s, f);
    fault = f;
    @(negedge clk);
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    e.cyc = base + 2 * DEPTH + RL;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    seed = DW'($urandom);
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < 2 * DEPTH + 100) begin
      @(negedge clk);
      t++;
      start = poke && (t == 10 || t == 180 || t == 250);
    end
    start = 1'b0;
    chk("done_seen", (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
    chk("mem_last", 32'(mem[DEPTH-1]), 32'(DW'(s + 16'd127)));
    chk("mem_0x10", 32'(mem[16]), 32'(DW'(s + 16'd16)));
    r = $urandom_range(0, DEPTH - 1);
    chk("mem_rand", 32'(mem[r]), 32'(DW'(s + DW'(r))));
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int base, d0;
    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_cen", 32'(mem_cen), 32'd1);
    chk("rst_wen", 32'(mem_wen), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_test(16'h0000, 0, 1'b0);
    run_test(16'hFFF0, 0, 1'b0);
    run_test(DW'($urandom), 1, 1'b0);
    run_test(DW'($urandom_range(1, 65408)), 2, 1'b0);
    run_test(DW'($urandom), 0, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_cen", 32'(mem_cen), 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    fault = 0;
    @(negedge clk);
    seed = DW'($urandom);
    start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 149) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cen", 32'(mem_cen), 32'd1);
    chk("midrst_wen", 32'(mem_wen), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err_count), 32'd0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (300) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 32'd0);

    run_test(DW'($urandom), 0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_test(DW'($urandom), int'($urandom_range(0, 1)), 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
